// File: rtl/motor_pkg.sv
// Shared types and combinational helpers for the motor sequencer: direction codes,
// sequencer states, per-wheel targets, the target decode and the duty ramp step.
package motor_pkg;

    localparam int DUTY_W = 16;

    typedef logic [DUTY_W-1:0] duty_t;

    typedef enum logic [3:0] {
        DIR_IDLE        = 4'd0,
        DIR_FORWARDS    = 4'd1,
        DIR_TURN        = 4'd2,
        DIR_TO_TABLE    = 4'd3,
        DIR_PAUSE       = 4'd4,
        DIR_BACKWARDS   = 4'd5,
        DIR_TURN_BACK   = 4'd6,
        DIR_RETURN_HOME = 4'd7,
        DIR_TO_FACE     = 4'd8,
        DIR_DONE        = 4'd9
    } dir_code_t;

    typedef enum logic [1:0] {
        SEQ_RUN   = 2'd0,
        SEQ_BRAKE = 2'd1,
        SEQ_DEAD  = 2'd2,
        SEQ_HALT  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic  dir;
        duty_t duty;
    } wheel_target_t;

    typedef struct packed {
        wheel_target_t left;
        wheel_target_t right;
    } target_pair_t;

    // Codes without a motion target keep the wheel's present direction at zero duty.
    function automatic target_pair_t decode_target(input logic [3:0] code,
                                                   input logic       cur_l,
                                                   input logic       cur_r,
                                                   input duty_t      duty_max,
                                                   input duty_t      duty_turn);
        target_pair_t t;
        t.left  = '{dir: cur_l, duty: '0};
        t.right = '{dir: cur_r, duty: '0};
        case (code)
            DIR_FORWARDS, DIR_TO_TABLE: begin
                t.left  = '{dir: 1'b1, duty: duty_max};
                t.right = '{dir: 1'b1, duty: duty_max};
            end
            DIR_TURN: begin
                t.left  = '{dir: 1'b1, duty: duty_turn};
                t.right = '{dir: 1'b1, duty: duty_max};
            end
            DIR_BACKWARDS, DIR_RETURN_HOME: begin
                t.left  = '{dir: 1'b0, duty: duty_max};
                t.right = '{dir: 1'b0, duty: duty_max};
            end
            DIR_TURN_BACK: begin
                t.left  = '{dir: 1'b0, duty: duty_turn};
                t.right = '{dir: 1'b0, duty: duty_max};
            end
            DIR_TO_FACE: begin
                t.left  = '{dir: 1'b0, duty: duty_turn};
                t.right = '{dir: 1'b1, duty: duty_turn};
            end
            default: ;
        endcase
        return t;
    endfunction

    // Differences are compared before stepping so the sum/difference never wraps.
    function automatic duty_t ramp_step(input duty_t cur, input duty_t tgt, input duty_t step);
        duty_t res;
        res = cur;
        if (cur < tgt) begin
            res = ((tgt - cur) > step) ? cur + step : tgt;
        end else if (cur > tgt) begin
            res = ((cur - tgt) > step) ? cur - step : tgt;
        end
        return res;
    endfunction

endpackage

// File: rtl/pwm_generator.sv
// Single-wheel PWM: free-running period counter compared against the duty register.
module pwm_generator
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD = 1000
) (
    input  logic  clk,
    input  logic  reset,
    input  duty_t duty,
    output logic  pwm
);

    localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_W'(PWM_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pwm = (duty_t'(cnt_q) < duty);

endmodule

// File: rtl/motor_sequencer.sv
// Maps navigation direction codes onto ramped left/right PWM duties and H-bridge
// direction pins, inserting brake and dead-time before any wheel reversal.
module motor_sequencer
    import motor_pkg::*;
#(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_MAX   = 800,
    parameter int DUTY_TURN  = 400,
    parameter int RAMP_STEP  = 8,
    parameter int RAMP_TICK  = 50000,
    parameter int DEADTIME   = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] direction,
    input  logic       estop,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic       dir_left,
    output logic       dir_right,
    output logic [1:0] seq_state,
    output logic       settled
);

    localparam int TICK_W = (RAMP_TICK > 1) ? $clog2(RAMP_TICK) : 1;
    localparam int DEAD_W = $clog2(DEADTIME + 1);
    localparam duty_t DUTY_MAX_V  = duty_t'(DUTY_MAX);
    localparam duty_t DUTY_TURN_V = duty_t'(DUTY_TURN);
    localparam duty_t STEP_V      = duty_t'(RAMP_STEP);

    // Index 0 is the left wheel, index 1 the right wheel.
    seq_state_t        state_q, state_d;
    duty_t [1:0]       duty_q, duty_d;
    logic  [1:0]       dir_q, dir_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              settled_q, settled_d;

    target_pair_t tgt;
    duty_t [1:0]  tgt_duty;
    logic  [1:0]  tgt_dir;
    logic         reversal;
    logic         tick;
    logic  [1:0]  pwm_w;

    always_comb begin
        tgt      = decode_target(direction, dir_q[0], dir_q[1], DUTY_MAX_V, DUTY_TURN_V);
        tgt_duty = {tgt.right.duty, tgt.left.duty};
        tgt_dir  = {tgt.right.dir, tgt.left.dir};
        reversal = 1'b0;
        for (int w = 0; w < 2; w++) begin
            if ((tgt_duty[w] != '0) && (tgt_dir[w] != dir_q[w])) begin
                reversal = 1'b1;
            end
        end
    end

    assign tick = (tick_cnt_q == TICK_W'(RAMP_TICK - 1));

    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        state_d    = state_q;
        duty_d     = duty_q;
        dir_d      = dir_q;
        dead_cnt_d = dead_cnt_q;
        if (estop) begin
            state_d = SEQ_HALT;
            duty_d  = '0;
        end else begin
            case (state_q)
                SEQ_RUN: begin
                    // The cycle that detects a reversal only changes state; ramping resumes in BRAKE.
                    if (reversal) begin
                        state_d    = (duty_q == '0) ? SEQ_DEAD : SEQ_BRAKE;
                        dead_cnt_d = DEAD_W'(1);
                    end else if (tick) begin
                        for (int w = 0; w < 2; w++) begin
                            duty_d[w] = ramp_step(duty_q[w], tgt_duty[w], STEP_V);
                        end
                    end
                end
                SEQ_BRAKE: begin
                    if (duty_q == '0) begin
                        state_d    = SEQ_DEAD;
                        dead_cnt_d = DEAD_W'(1);
                    end else if (tick) begin
                        for (int w = 0; w < 2; w++) begin
                            duty_d[w] = ramp_step(duty_q[w], '0, STEP_V);
                        end
                    end
                end
                SEQ_DEAD: begin
                    if (dead_cnt_q == DEAD_W'(DEADTIME)) begin
                        state_d = SEQ_RUN;
                        for (int w = 0; w < 2; w++) begin
                            if (tgt_duty[w] != '0) begin
                                dir_d[w] = tgt_dir[w];
                            end
                        end
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
                SEQ_HALT: begin
                    state_d    = SEQ_DEAD;
                    dead_cnt_d = DEAD_W'(1);
                end
                default: state_d = SEQ_RUN;
            endcase
        end
        settled_d = (state_d == SEQ_RUN) && (duty_d == tgt_duty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SEQ_RUN;
            duty_q     <= '0;
            dir_q      <= 2'b11;
            tick_cnt_q <= '0;
            dead_cnt_q <= '0;
            settled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            duty_q     <= duty_d;
            dir_q      <= dir_d;
            tick_cnt_q <= tick_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            settled_q  <= settled_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_wheel
        pwm_generator #(
            .PWM_PERIOD (PWM_PERIOD)
        ) u_pwm (
            .clk   (clk),
            .reset (reset),
            .duty  (duty_q[gi]),
            .pwm   (pwm_w[gi])
        );
    end

    assign pwm_left  = pwm_w[0];
    assign pwm_right = pwm_w[1];
    assign dir_left  = dir_q[0];
    assign dir_right = dir_q[1];
    assign seq_state = state_q;
    assign settled   = settled_q;

endmodule

// File: tb/tb_motor_sequencer.sv
// Directed and randomized checks of motor_sequencer against a cycle-level reference
// model built from the direction table, tick/PWM arithmetic and dead-time timestamps.
module tb_motor_sequencer;

    localparam int PWM_PERIOD = 10;
    localparam int DUTY_MAX   = 8;
    localparam int DUTY_TURN  = 4;
    localparam int RAMP_STEP  = 2;
    localparam int RAMP_TICK  = 4;
    localparam int DEADTIME   = 6;
    localparam int M = DUTY_MAX;
    localparam int T = DUTY_TURN;

    logic       clk;
    logic       reset;
    logic [3:0] direction;
    logic       estop;
    logic       pwm_left, pwm_right, dir_left, dir_right, settled;
    logic [1:0] seq_state;

    motor_sequencer #(
        .PWM_PERIOD (PWM_PERIOD),
        .DUTY_MAX   (DUTY_MAX),
        .DUTY_TURN  (DUTY_TURN),
        .RAMP_STEP  (RAMP_STEP),
        .RAMP_TICK  (RAMP_TICK),
        .DEADTIME   (DEADTIME)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .direction (direction),
        .estop     (estop),
        .pwm_left  (pwm_left),
        .pwm_right (pwm_right),
        .dir_left  (dir_left),
        .dir_right (dir_right),
        .seq_state (seq_state),
        .settled   (settled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target table by direction code: duty per wheel and dir (1 = forward).
    int tab_duty_l [16] = '{0, M, T, M, 0, M, T, M, T, 0, 0, 0, 0, 0, 0, 0};
    int tab_duty_r [16] = '{0, M, M, M, 0, M, M, M, T, 0, 0, 0, 0, 0, 0, 0};
    int tab_dir_l  [16] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int tab_dir_r  [16] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};

    int compared   = 0;
    int mismatched = 0;

    // Reference model: m_cyc counts cycles since reset; phase 0 RUN,1 BRAKE,2 DEAD,3 HALT.
    int m_cyc, m_phase, m_dead_start, m_settled;
    int m_duty [2];
    int m_dir  [2];

    function automatic int approach(input int cur, input int goal);
        if (cur < goal) return (cur + RAMP_STEP > goal) ? goal : cur + RAMP_STEP;
        if (cur > goal) return (cur - RAMP_STEP < goal) ? goal : cur - RAMP_STEP;
        return cur;
    endfunction

    task automatic model_edge();
        int c;
        int goal_duty [2];
        int goal_dir  [2];
        bit rev, on_tick;
        if (reset) begin
            m_cyc = 0; m_phase = 0; m_settled = 0; m_dead_start = 0;
            for (int w = 0; w < 2; w++) begin m_duty[w] = 0; m_dir[w] = 1; end
            return;
        end
        c = m_cyc;
        m_cyc = c + 1;
        on_tick = ((c % RAMP_TICK) == RAMP_TICK - 1);
        goal_duty[0] = tab_duty_l[direction];
        goal_duty[1] = tab_duty_r[direction];
        goal_dir[0]  = (goal_duty[0] != 0) ? tab_dir_l[direction] : m_dir[0];
        goal_dir[1]  = (goal_duty[1] != 0) ? tab_dir_r[direction] : m_dir[1];
        rev = 0;
        for (int w = 0; w < 2; w++) if (goal_duty[w] != 0 && goal_dir[w] != m_dir[w]) rev = 1;
        if (estop) begin
            m_phase = 3;
            m_duty[0] = 0; m_duty[1] = 0;
        end else if (m_phase == 0) begin
            if (rev) begin
                if (m_duty[0] + m_duty[1] == 0) begin m_phase = 2; m_dead_start = m_cyc; end
                else m_phase = 1;
            end else if (on_tick) begin
                for (int w = 0; w < 2; w++) m_duty[w] = approach(m_duty[w], goal_duty[w]);
            end
        end else if (m_phase == 1) begin
            if (m_duty[0] + m_duty[1] == 0) begin m_phase = 2; m_dead_start = m_cyc; end
            else if (on_tick) for (int w = 0; w < 2; w++) m_duty[w] = approach(m_duty[w], 0);
        end else if (m_phase == 2) begin
            if (c - m_dead_start + 1 >= DEADTIME) begin
                m_phase = 0;
                for (int w = 0; w < 2; w++) if (goal_duty[w] != 0) m_dir[w] = goal_dir[w];
            end
        end else begin
            m_phase = 2;
            m_dead_start = m_cyc;
        end
        m_settled = (m_phase == 0 && m_duty[0] == goal_duty[0] && m_duty[1] == goal_duty[1]) ? 1 : 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at model cycle %0d: observed %0d, expected %0d", tag, m_cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("duty_left",  32'(dut.duty_q[0]), 32'(m_duty[0]));
        check("duty_right", 32'(dut.duty_q[1]), 32'(m_duty[1]));
        check("dir_left",   32'(dir_left),  32'(m_dir[0]));
        check("dir_right",  32'(dir_right), 32'(m_dir[1]));
        check("seq_state",  32'(seq_state), 32'(m_phase));
        check("settled",    32'(settled),   32'(m_settled));
        check("pwm_left",   32'(pwm_left),  32'(((m_cyc % PWM_PERIOD) < m_duty[0]) ? 1 : 0));
        check("pwm_right",  32'(pwm_right), 32'(((m_cyc % PWM_PERIOD) < m_duty[1]) ? 1 : 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int cnt_l, cnt_r, dead_cycles, n;
        bit stayed_run;
        reset = 1'b1; direction = 4'd0; estop = 1'b0;
        run(2);
        check("reset_state", 32'(seq_state), 32'd0);
        check("reset_dirs",  32'({dir_left, dir_right}), 32'd3);
        check("reset_pwm",   32'({pwm_left, pwm_right}), 32'd0);
        check("reset_settled", 32'(settled), 32'd0);
        reset = 1'b0;
        $display("step reset done");

        direction = 4'd1;
        run(24);
        check("fwd_settled", 32'(settled), 32'd1);
        cnt_l = 0; cnt_r = 0;
        for (int i = 0; i < PWM_PERIOD; i++) begin
            cycle();
            cnt_l += int'(pwm_left);
            cnt_r += int'(pwm_right);
        end
        check("fwd_pwm_high_left", 32'(cnt_l), 32'd8);
        check("fwd_pwm_high_right", 32'(cnt_r), 32'd8);
        $display("step forward ramp: pwm high %0d/%0d of %0d", cnt_l, cnt_r, PWM_PERIOD);

        direction = 4'd2;
        stayed_run = 1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (seq_state != 2'd0) stayed_run = 0;
        end
        check("turn_stays_run", 32'(stayed_run), 32'd1);
        check("turn_duty_left", 32'(dut.duty_q[0]), 32'd4);
        check("turn_duty_right", 32'(dut.duty_q[1]), 32'd8);
        check("turn_dirs", 32'({dir_left, dir_right}), 32'd3);
        $display("step turn: left duty %0d right duty %0d", dut.duty_q[0], dut.duty_q[1]);

        direction = 4'd1;
        run(20);
        direction = 4'd5;
        dead_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (seq_state == 2'd2) begin
                dead_cycles++;
                check("dead_pwm_low", 32'({pwm_left, pwm_right}), 32'd0);
            end
        end
        check("reverse_dead_len", 32'(dead_cycles), 32'(DEADTIME));
        check("reverse_dirs", 32'({dir_left, dir_right}), 32'd0);
        check("reverse_duty", 32'(dut.duty_q[0]), 32'd8);
        $display("step reverse: dead cycles %0d", dead_cycles);

        direction = 4'd1;
        run(60);
        estop = 1'b1;
        cycle();
        check("estop_pwm_low", 32'({pwm_left, pwm_right}), 32'd0);
        check("estop_state", 32'(seq_state), 32'd3);
        run(2);
        estop = 1'b0;
        dead_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (seq_state == 2'd2) dead_cycles++;
        end
        check("estop_dead_len", 32'(dead_cycles), 32'(DEADTIME));
        check("estop_dirs", 32'({dir_left, dir_right}), 32'd3);
        check("estop_resettle", 32'(settled), 32'd1);
        $display("step estop: dead cycles %0d", dead_cycles);

        direction = 4'd12;
        run(30);
        check("zero_duty", 32'(dut.duty_q[0]), 32'd0);
        check("zero_dirs", 32'({dir_left, dir_right}), 32'd3);
        check("zero_settled", 32'(settled), 32'd1);
        $display("step code 12: duties ramped down");

        direction = 4'd1;
        run(30);
        direction = 4'd5;
        n = 0;
        while (seq_state != 2'd1 && n < 20) begin
            cycle();
            n++;
        end
        check("reach_brake", 32'(seq_state), 32'd1);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("mid_reset_duty", 32'(dut.duty_q[0]), 32'd0);
        check("mid_reset_dirs", 32'({dir_left, dir_right}), 32'd3);
        check("mid_reset_state", 32'(seq_state), 32'd0);
        check("mid_reset_pwm", 32'({pwm_left, pwm_right}), 32'd0);
        $display("step mid-brake reset");

        for (int seg = 0; seg < 120; seg++) begin
            int hold;
            direction = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 40);
            estop = ($urandom_range(0, 19) == 0);
            reset = ($urandom_range(0, 49) == 0);
            cycle();
            reset = 1'b0;
            if (estop) begin
                run($urandom_range(0, 3));
                estop = 1'b0;
            end
            run(hold);
            $display("random seg %0d: direction %0d held %0d state %0d", seg, direction, hold, seq_state);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
